// File: rtl/demux_1to4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Holds the port count, sel width, port-index encoding and a decode helper.
package demux_1to4_buf_pkg;

  localparam int NumPorts = 4;
  localparam int SelW     = 2;

  typedef logic [SelW-1:0] sel_t;

  // sel value addressing each output port
  typedef enum logic [SelW-1:0] {
    PORT0 = 2'd0,
    PORT1 = 2'd1,
    PORT2 = 2'd2,
    PORT3 = 2'd3
  } port_e;

  // One-hot decode of a port index
  function automatic logic [NumPorts-1:0] port_onehot(input sel_t s);
    logic [NumPorts-1:0] oh;
    oh = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (s == SelW'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/demux_1to4_buf_if.sv
// Bus bundle between an upstream producer, the demux and its four consumers.
// Latency: n/a (wiring only).
// Backpressure: ready_o toward upstream, ready_i[3:0] from consumers.
// Signals: sel/valid_i/data_i/flush_i (upstream in), ready_o (to upstream),
//          valid_o/data0_o..data3_o (to consumers), ready_i (from consumers).
interface demux_1to4_buf_if #(parameter int Size = 64);
  import demux_1to4_buf_pkg::*;

  sel_t                sel;
  logic                valid_i;
  logic [Size-1:0]     data_i;
  logic                ready_o;
  logic                flush_i;
  logic [NumPorts-1:0] valid_o;
  logic [Size-1:0]     data0_o;
  logic [Size-1:0]     data1_o;
  logic [Size-1:0]     data2_o;
  logic [Size-1:0]     data3_o;
  logic [NumPorts-1:0] ready_i;

  // Environment side: drives upstream and consumer controls
  modport master (
    output sel, valid_i, data_i, flush_i, ready_i,
    input  ready_o, valid_o, data0_o, data1_o, data2_o, data3_o
  );

  // Demux side
  modport slave (
    input  sel, valid_i, data_i, flush_i, ready_i,
    output ready_o, valid_o, data0_o, data1_o, data2_o, data3_o
  );

endinterface

// File: rtl/demux_1to4_buf_slot.sv
// One-entry output buffer: full flag plus data register.
// Latency: 1 cycle from load to full.
// Backpressure: holds its word while not drained; parent must only load when empty or draining.
// Ports: clk, rst_n, load, drain, flush, data_in -> full, data_out.
module demux_slot #(
  parameter int Size = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [Size-1:0] data_in,
  output logic            full,
  output logic [Size-1:0] data_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      data_out <= '0;
    end else begin
      // flush beats load; load beats drain so a same-cycle refill stays full
      if (flush)      full <= 1'b0;
      else if (load)  full <= 1'b1;
      else if (drain) full <= 1'b0;

      // data only changes on an accepted load; otherwise it holds
      if (load && !flush) data_out <= data_in;
    end
  end

endmodule

// File: rtl/demux_1to4_buf.sv
// Routes one upstream word per cycle into one of four one-entry port buffers.
// Latency: 1 cycle from input acceptance to valid_o[sel].
// Backpressure: ready_o drops when the addressed slot is full and not draining, or on flush.
// Ports: clk, rst_n, bus (slave modport: sel, valid_i, data_i, flush_i, ready_i in;
//        ready_o, valid_o, data0_o..data3_o out).
module demux_1to4_buf
  import demux_1to4_buf_pkg::*;
#(
  parameter int Size = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1to4_buf_if.slave     bus
);

  logic [NumPorts-1:0] full;
  logic [NumPorts-1:0] load;
  logic [NumPorts-1:0] drain;
  logic [NumPorts-1:0] sel_oh;
  logic [Size-1:0]     slot_dat [NumPorts];
  logic                rdy;

  assign sel_oh = port_onehot(bus.sel);

  // Only the addressed slot's state matters; valid_i is deliberately absent
  assign rdy   = ~bus.flush_i & (~full[bus.sel] | bus.ready_i[bus.sel]);
  assign load  = (bus.valid_i && rdy) ? sel_oh : '0;
  assign drain = full & bus.ready_i;

  for (genvar k = 0; k < NumPorts; k++) begin : g_slot
    demux_slot #(.Size(Size)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .drain    (drain[k]),
      .flush    (bus.flush_i),
      .data_in  (bus.data_i),
      .full     (full[k]),
      .data_out (slot_dat[k])
    );
  end

  assign bus.ready_o = rdy;
  assign bus.valid_o = full;
  assign bus.data0_o = slot_dat[0];
  assign bus.data1_o = slot_dat[1];
  assign bus.data2_o = slot_dat[2];
  assign bus.data3_o = slot_dat[3];

endmodule
